// File: rtl/sm83_bus_target_if.sv
// SM83 CPU/memory bus bundle: slave is the bus target, master is the CPU plus memory-block side.
// No internal latency; request hold-until-ack is the only backpressure.
interface sm83_bus_target_if;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_dout;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        dma_active;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic        proto_err;
    logic [15:0] mem_adr;
    logic [6:0]  mem_cs;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_adr, cpu_dout, cpu_rd, cpu_wr, dma_active, mem_rdata,
        output cpu_din, cpu_ack, proto_err, mem_adr, mem_cs, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output cpu_adr, cpu_dout, cpu_rd, cpu_wr, dma_active, mem_rdata,
        input  cpu_din, cpu_ack, proto_err, mem_adr, mem_cs, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/sm83_bus_target.sv
// SM83 bus responder: latches and decodes a CPU request, strobes one DMG region, returns data.
// Fixed 4-state M-cycle, ack three cycles after the request is latched; CPU holds rd/wr until ack.
module sm83_bus_target #(
    parameter logic [7:0] OPEN_BUS   = 8'hFF,
    parameter logic [7:0] UNUSED_VAL = 8'h00,
    parameter bit         ECHO_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    sm83_bus_target_if.slave  bus
);
    localparam int CS_ROM  = 0;
    localparam int CS_VRAM = 1;
    localparam int CS_EXT  = 2;
    localparam int CS_WRAM = 3;
    localparam int CS_OAM  = 4;
    localparam int CS_IO   = 5;
    localparam int CS_HRAM = 6;

    typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_CAPTURE, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] adr_q, adr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [6:0]  cs_q, cs_d;
    logic [7:0]  sub_q, sub_d;
    logic [7:0]  din_q, din_d;
    logic        perr_q, perr_d;

    logic [6:0]  dec_cs;
    logic [15:0] dec_adr;
    logic [7:0]  dec_sub;

    // Region decode; a blocked or unused access leaves dec_cs zero and picks its substitute read value.
    always_comb begin
        dec_cs  = '0;
        dec_adr = bus.cpu_adr;
        dec_sub = OPEN_BUS;
        if (!bus.cpu_adr[15]) begin
            dec_cs[CS_ROM] = 1'b1;
        end else if (bus.cpu_adr[15:13] == 3'b100) begin
            dec_cs[CS_VRAM] = 1'b1;
        end else if (bus.cpu_adr[15:13] == 3'b101) begin
            dec_cs[CS_EXT] = 1'b1;
        end else if (bus.cpu_adr[15:13] == 3'b110) begin
            dec_cs[CS_WRAM] = 1'b1;
        end else if (bus.cpu_adr < 16'hFE00) begin
            if (ECHO_EN) begin
                dec_cs[CS_WRAM] = 1'b1;
                dec_adr         = bus.cpu_adr & 16'hDFFF;
            end
        end else if (bus.cpu_adr < 16'hFEA0) begin
            dec_cs[CS_OAM] = 1'b1;
        end else if (bus.cpu_adr < 16'hFF00) begin
            dec_sub = UNUSED_VAL;
        end else if (bus.cpu_adr < 16'hFF80 || bus.cpu_adr == 16'hFFFF) begin
            dec_cs[CS_IO] = 1'b1;
        end else begin
            dec_cs[CS_HRAM] = 1'b1;
        end

        if (bus.dma_active && !dec_cs[CS_HRAM]) begin
            dec_cs  = '0;
            dec_sub = OPEN_BUS;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        cs_d    = cs_q;
        sub_d   = sub_q;
        din_d   = din_q;
        perr_d  = perr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_rd || bus.cpu_wr) begin
                    state_d = ST_STROBE;
                    adr_d   = dec_adr;
                    wdata_d = bus.cpu_dout;
                    wr_d    = bus.cpu_wr;
                    cs_d    = dec_cs;
                    sub_d   = dec_sub;
                    if (bus.cpu_rd && bus.cpu_wr) begin
                        perr_d = 1'b1;
                    end
                end
            end
            ST_STROBE: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                state_d = ST_DONE;
                if (!wr_q) begin
                    din_d = (cs_q == '0) ? sub_q : bus.mem_rdata;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cs_q    <= '0;
            sub_q   <= '0;
            din_q   <= 8'h00;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            cs_q    <= cs_d;
            sub_q   <= sub_d;
            din_q   <= din_d;
            perr_q  <= perr_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them in the same instant.
    assign bus.mem_cs    = (state_q == ST_STROBE || state_q == ST_CAPTURE) ? cs_q : 7'd0;
    assign bus.mem_rd    = (state_q == ST_STROBE) && !wr_q && (cs_q != '0);
    assign bus.mem_wr    = (state_q == ST_STROBE) && wr_q && (cs_q != '0);
    assign bus.mem_adr   = adr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = (state_q == ST_DONE);
    assign bus.cpu_din   = din_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_sm83_bus_target.sv
// Directed bench for sm83_bus_target: hand-computed vectors per region, DMA, echo, back-to-back, reset.
module tb_sm83_bus_target;
    logic clk;
    logic reset_n;

    sm83_bus_target_if bus_if ();

    sm83_bus_target dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_bad = 0;

    logic [6:0]  cs_s [3];
    logic [15:0] adr_s;
    logic [7:0]  wd_s;
    logic [7:0]  din_s;
    logic        ack_done;
    int          n_rd, n_wr, n_ack;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge of the following idle cycle.
    task automatic txn(input logic [15:0] adr, input logic [7:0] dout, input logic rd,
                       input logic wr, input logic dma, input logic [7:0] rdata);
        bus_if.cpu_adr    = adr;
        bus_if.cpu_dout   = dout;
        bus_if.cpu_rd     = rd;
        bus_if.cpu_wr     = wr;
        bus_if.dma_active = dma;
        bus_if.mem_rdata  = rdata;
        n_rd  = 0;
        n_wr  = 0;
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cs_s[i] = bus_if.mem_cs;
            n_rd  += int'(bus_if.mem_rd);
            n_wr  += int'(bus_if.mem_wr);
            n_ack += int'(bus_if.cpu_ack);
            if (i == 0) begin
                adr_s = bus_if.mem_adr;
                wd_s  = bus_if.mem_wdata;
                // Late input changes must not disturb the latched transaction.
                bus_if.cpu_adr    = 16'h0000;
                bus_if.cpu_dout   = 8'hEE;
                bus_if.dma_active = ~dma;
            end
        end
        ack_done = bus_if.cpu_ack;
        din_s    = bus_if.cpu_din;
        bus_if.cpu_rd     = 1'b0;
        bus_if.cpu_wr     = 1'b0;
        bus_if.dma_active = 1'b0;
        @(negedge clk);
        n_rd  += int'(bus_if.mem_rd);
        n_wr  += int'(bus_if.mem_wr);
        n_ack += int'(bus_if.cpu_ack);
    endtask

    int ack_at [2];
    int n_b2b;

    initial begin
        reset_n           = 1'b0;
        bus_if.cpu_adr    = 16'h0000;
        bus_if.cpu_dout   = 8'h00;
        bus_if.cpu_rd     = 1'b0;
        bus_if.cpu_wr     = 1'b0;
        bus_if.dma_active = 1'b0;
        bus_if.mem_rdata  = 8'h00;
        #12;
        chk_eq("rst_ack",  bus_if.cpu_ack,   0);
        chk_eq("rst_cs",   bus_if.mem_cs,    0);
        chk_eq("rst_rdwr", {bus_if.mem_rd, bus_if.mem_wr}, 0);
        chk_eq("rst_din",  bus_if.cpu_din,   8'h00);
        chk_eq("rst_perr", bus_if.proto_err, 0);
        chk_eq("rst_adr",  bus_if.mem_adr,   0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // WRAM read
        txn(16'hC123, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A);
        chk_eq("wram_cs_strobe", cs_s[0], 7'b0001000);
        chk_eq("wram_cs_capt",   cs_s[1], 7'b0001000);
        chk_eq("wram_cs_done",   cs_s[2], 7'b0000000);
        chk_eq("wram_rd_cnt",    n_rd, 1);
        chk_eq("wram_adr",       adr_s, 16'hC123);
        chk_eq("wram_ack_done",  ack_done, 1);
        chk_eq("wram_ack_cnt",   n_ack, 1);
        chk_eq("wram_din",       din_s, 8'h5A);

        // Echo write folds into WRAM
        txn(16'hF000, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h77);
        chk_eq("echo_adr",    adr_s, 16'hD000);
        chk_eq("echo_cs",     cs_s[0], 7'b0001000);
        chk_eq("echo_wr_cnt", n_wr, 1);
        chk_eq("echo_rd_cnt", n_rd, 0);
        chk_eq("echo_wdata",  wd_s, 8'h3C);
        chk_eq("echo_din",    din_s, 8'h5A);
        chk_eq("echo_ack",    n_ack, 1);

        // DMA blocks VRAM, not HRAM
        txn(16'h8000, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77);
        chk_eq("dma_vram_din", din_s, 8'hFF);
        chk_eq("dma_vram_rd",  n_rd, 0);
        chk_eq("dma_vram_cs",  cs_s[0] | cs_s[1], 0);
        chk_eq("dma_vram_ack", ack_done, 1);
        txn(16'hFF90, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42);
        chk_eq("dma_hram_cs",  cs_s[0], 7'b1000000);
        chk_eq("dma_hram_rd",  n_rd, 1);
        chk_eq("dma_hram_din", din_s, 8'h42);

        // Unused region, IO at FFFF, ROM, OAM, write with no DMA while input dma toggles late
        txn(16'hFEA5, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33);
        chk_eq("unused_din", din_s, 8'h00);
        chk_eq("unused_cs",  cs_s[0] | cs_s[1], 0);
        chk_eq("unused_rd",  n_rd, 0);
        txn(16'hFFFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11);
        chk_eq("ie_cs",  cs_s[0], 7'b0100000);
        chk_eq("ie_din", din_s, 8'h11);
        txn(16'hFF7F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12);
        chk_eq("io_top_cs", cs_s[0], 7'b0100000);
        txn(16'h7FFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h99);
        chk_eq("rom_cs",  cs_s[0], 7'b0000001);
        chk_eq("rom_din", din_s, 8'h99);
        txn(16'hFE9F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h21);
        chk_eq("oam_cs",  cs_s[0], 7'b0010000);
        txn(16'hFE00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22);
        chk_eq("oam_lo_cs", cs_s[0], 7'b0010000);
        txn(16'hFDFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h23);
        chk_eq("echo_top_adr", adr_s, 16'hDDFF);
        chk_eq("echo_top_cs",  cs_s[0], 7'b0001000);
        txn(16'hFF80, 8'h00, 1'b1, 1'b0, 1'b0, 8'h24);
        chk_eq("hram_lo_cs", cs_s[0], 7'b1000000);

        // Protocol error: rd and wr together run as a write
        chk_eq("perr_before", bus_if.proto_err, 0);
        txn(16'h9000, 8'hAB, 1'b1, 1'b1, 1'b0, 8'h44);
        chk_eq("perr_cs",    cs_s[0], 7'b0000010);
        chk_eq("perr_wr",    n_wr, 1);
        chk_eq("perr_rd",    n_rd, 0);
        chk_eq("perr_wdata", wd_s, 8'hAB);
        chk_eq("perr_din",   din_s, 8'h24);
        chk_eq("perr_set",   bus_if.proto_err, 1);
        txn(16'hA000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55);
        chk_eq("ext_cs",      cs_s[0], 7'b0000100);
        chk_eq("perr_sticky", bus_if.proto_err, 1);

        // Back-to-back reads: second request already present in the idle cycle after DONE
        bus_if.cpu_adr   = 16'h0100;
        bus_if.cpu_rd    = 1'b1;
        bus_if.mem_rdata = 8'h66;
        n_b2b     = 0;
        ack_at[0] = -1;
        ack_at[1] = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                chk_eq("b2b_adr2", bus_if.mem_adr, 16'h0101);
                chk_eq("b2b_rd2",  bus_if.mem_rd, 1);
            end
            if (bus_if.cpu_ack) begin
                if (n_b2b < 2) ack_at[n_b2b] = i;
                n_b2b++;
                bus_if.cpu_adr = 16'h0101;
                if (n_b2b == 2) bus_if.cpu_rd = 1'b0;
            end
        end
        chk_eq("b2b_acks",  n_b2b, 2);
        chk_eq("b2b_first", ack_at[0], 3);
        chk_eq("b2b_gap",   ack_at[1] - ack_at[0], 4);

        // Reset during STROBE
        bus_if.cpu_adr = 16'h8000;
        bus_if.cpu_rd  = 1'b1;
        @(negedge clk);
        chk_eq("mid_rd_before", bus_if.mem_rd, 1);
        #2;
        reset_n       = 1'b0;
        bus_if.cpu_rd = 1'b0;
        #1;
        chk_eq("mid_rd_drop", bus_if.mem_rd, 0);
        chk_eq("mid_cs_drop", bus_if.mem_cs, 0);
        chk_eq("mid_din",     bus_if.cpu_din, 8'h00);
        chk_eq("mid_perr",    bus_if.proto_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        n_ack = 0;
        n_rd  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_ack += int'(bus_if.cpu_ack);
            n_rd  += int'(bus_if.mem_rd);
        end
        chk_eq("mid_no_ack", n_ack, 0);
        chk_eq("mid_no_rd",  n_rd, 0);

        // FSM back in IDLE: a fresh read completes normally
        txn(16'hC000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3E);
        chk_eq("post_rst_ack", ack_done, 1);
        chk_eq("post_rst_din", din_s, 8'h3E);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
